// File: rtl/press_classifier_pkg.sv
// Shared definitions for the button gesture classifier: FSM state encodings and
// default timing constants (also reused by the debouncer tick).
package press_classifier_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRESS1 = 3'd1,
      S_LONG   = 3'd2,
      S_GAP    = 3'd3,
      S_PRESS2 = 3'd4
   } state_t;

   localparam int DEF_TICK_DIV  = 100000;
   localparam int DEF_LONG_MS   = 500;
   localparam int DEF_DCLICK_MS = 250;
   localparam int DEF_MS_W      = 10;

endpackage

// File: rtl/press_classifier_ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, used as the
// classifier's 1 ms time base.
import press_classifier_pkg::*;

module ms_tick_gen #(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/press_classifier.sv
// Button gesture classifier: turns the debounced level into short / long /
// double-click pulses, a held level and a wrapping press counter.
import press_classifier_pkg::*;

module press_classifier #(
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int LONG_MS   = DEF_LONG_MS,
   parameter int DCLICK_MS = DEF_DCLICK_MS,
   parameter int MS_W      = DEF_MS_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       db,
   output logic       short_p,
   output logic       long_p,
   output logic       double_p,
   output logic       held,
   output logic [7:0] press_cnt
);

   localparam logic [MS_W-1:0] MS_MAX      = '1;
   localparam logic [MS_W-1:0] LONG_LAST   = MS_W'(LONG_MS - 1);
   localparam logic [MS_W-1:0] DCLICK_LAST = MS_W'(DCLICK_MS - 1);

   logic            db_d;
   logic            rise;
   logic            fall;
   logic            tick;
   logic [MS_W-1:0] ms_cnt;
   state_t          state;
   state_t          state_nxt;
   logic            short_nxt;
   logic            long_nxt;
   logic            double_nxt;

   ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // db_d resets low, so a button already held at reset release reads as a rise
   assign rise = db & ~db_d;
   assign fall = ~db & db_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Edges are tested before timeouts so an edge always wins a same-cycle race
   always_comb begin
      state_nxt  = state;
      short_nxt  = 1'b0;
      long_nxt   = 1'b0;
      double_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (rise) state_nxt = S_PRESS1;
         end
         S_PRESS1: begin
            if (fall) begin
               state_nxt = S_GAP;
            end else if (tick && ms_cnt == LONG_LAST) begin
               state_nxt = S_LONG;
               long_nxt  = 1'b1;
            end
         end
         S_LONG: begin
            if (fall) state_nxt = S_IDLE;
         end
         S_GAP: begin
            if (rise) begin
               state_nxt = S_PRESS2;
            end else if (tick && ms_cnt == DCLICK_LAST) begin
               state_nxt = S_IDLE;
               short_nxt = 1'b1;
            end
         end
         S_PRESS2: begin
            if (fall) begin
               state_nxt  = S_IDLE;
               double_nxt = 1'b1;
            end else if (tick && ms_cnt == LONG_LAST) begin
               state_nxt = S_LONG;
               short_nxt = 1'b1;
               long_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ms_cnt <= '0;
      else if (state_nxt != state)
         ms_cnt <= '0;
      else if (tick && ms_cnt != MS_MAX)
         ms_cnt <= ms_cnt + MS_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_d      <= 1'b0;
         press_cnt <= '0;
         short_p   <= 1'b0;
         long_p    <= 1'b0;
         double_p  <= 1'b0;
      end else begin
         db_d      <= db;
         short_p   <= short_nxt;
         long_p    <= long_nxt;
         double_p  <= double_nxt;
         if (rise) press_cnt <= press_cnt + 8'(1);
      end
   end

   assign held = (state == S_LONG);

endmodule

// File: tb/tb_press_classifier.sv
// Randomised and directed stimulus for press_classifier, checked by a scoreboard
// fed from a gesture-level reference model.
module tb_press_classifier;

   localparam int TD  = 4;
   localparam int LM  = 10;
   localparam int DM  = 5;
   localparam int MSW = 10;
   localparam int SAT = (1 << MSW) - 1;

   localparam int P_IDLE = 0, P_PRESS1 = 1, P_LONG = 2, P_GAP = 3, P_PRESS2 = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       db;
   logic       short_p, long_p, double_p, held;
   logic [7:0] press_cnt;

   press_classifier #(.TICK_DIV(TD), .LONG_MS(LM), .DCLICK_MS(DM), .MS_W(MSW)) dut (
      .clk       (clk),
      .reset     (reset),
      .db        (db),
      .short_p   (short_p),
      .long_p    (long_p),
      .double_p  (double_p),
      .held      (held),
      .press_cnt (press_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit s;
      bit l;
      bit d;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  exp_cnt = 0;
   bit  exp_held = 0;
   int  n_short = 0, n_long = 0, n_double = 0;

   // Reference model: the gesture phase plus elapsed whole ms, advanced per clock
   initial begin : model
      int  phase, ms, presc, nphase;
      bit  prev, tk, rs, fl, s, l, d;
      phase = P_IDLE; ms = 0; presc = 0; prev = 0;
      forever begin
         @(posedge clk or posedge reset);
         cyc++;
         if (reset) begin
            phase = P_IDLE; ms = 0; presc = 0; prev = 0;
            exp_cnt = 0; exp_held = 0;
            q.delete();
         end else begin
            tk = (presc == TD - 1);
            presc = tk ? 0 : presc + 1;
            rs = db && !prev;
            fl = !db && prev;
            prev = db;
            if (rs) exp_cnt = (exp_cnt + 1) % 256;
            s = 0; l = 0; d = 0;
            nphase = phase;
            if (phase == P_IDLE && rs) nphase = P_PRESS1;
            else if (phase == P_PRESS1 && fl) nphase = P_GAP;
            else if (phase == P_PRESS1 && tk && ms + 1 == LM) begin nphase = P_LONG; l = 1; end
            else if (phase == P_LONG && fl) nphase = P_IDLE;
            else if (phase == P_GAP && rs) nphase = P_PRESS2;
            else if (phase == P_GAP && tk && ms + 1 == DM) begin nphase = P_IDLE; s = 1; end
            else if (phase == P_PRESS2 && fl) begin nphase = P_IDLE; d = 1; end
            else if (phase == P_PRESS2 && tk && ms + 1 == LM) begin nphase = P_LONG; s = 1; l = 1; end
            if (nphase != phase) ms = 0;
            else if (tk && ms < SAT) ms++;
            phase = nphase;
            exp_held = (phase == P_LONG);
            if (s || l || d) q.push_back('{cyc: cyc, s: s, l: l, d: d});
         end
      end
   end

   // Monitor: levels every cycle, pulses popped from the scoreboard when seen
   always @(negedge clk) begin
      checks++;
      if (held !== exp_held) begin
         failures++;
         $display("FAIL held cyc=%0d got=%b want=%b", cyc, held, exp_held);
      end
      checks++;
      if (press_cnt !== 8'(exp_cnt)) begin
         failures++;
         $display("FAIL press_cnt cyc=%0d got=%0d want=%0d", cyc, press_cnt, exp_cnt);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
         checks++;
         failures++;
         $display("FAIL missing_pulse cyc=%0d got=none want=s%0b l%0b d%0b@%0d",
                  cyc, q[0].s, q[0].l, q[0].d, q[0].cyc);
         void'(q.pop_front());
      end
      if (short_p || long_p || double_p) begin
         n_short  += int'(short_p);
         n_long   += int'(long_p);
         n_double += int'(double_p);
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d got=s%0b l%0b d%0b want=none",
                     cyc, short_p, long_p, double_p);
         end else begin
            ev_t e;
            e = q.pop_front();
            if (e.cyc != cyc || e.s != short_p || e.l != long_p || e.d != double_p) begin
               failures++;
               $display("FAIL pulse cyc=%0d got=s%0b l%0b d%0b want=s%0b l%0b d%0b@%0d",
                        cyc, short_p, long_p, double_p, e.s, e.l, e.d, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic drive(input bit v, input int n);
      db = v;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check_zero(input string name);
      check({name, "_outs"}, int'({short_p, long_p, double_p, held}), 0);
      check({name, "_cnt"}, int'(press_cnt), 0);
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1;
      #1;
      check_zero(name);
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      reset = 1'b0;
      n_short = 0; n_long = 0; n_double = 0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      reset = 1'b1;
      db    = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #2;
      end
      check_zero("reset_hold");
      reset = 1'b0;
      drive(0, 100);
      check("idle_pulses", n_short + n_long + n_double, 0);

      // short click
      do_reset("r2");
      drive(1, 12);
      drive(0, 10);
      check("short_gap_quiet", n_short, 0);
      drive(0, 30);
      check("short_once", n_short, 1);
      check("short_cnt", int'(press_cnt), 1);

      // long press
      do_reset("r3");
      drive(1, 60);
      check("long_once", n_long, 1);
      check("long_held", int'(held), 1);
      drive(0, 40);
      check("long_released", int'(held), 0);
      check("long_no_short", n_short, 0);

      // double click
      do_reset("r4");
      drive(1, 8); drive(0, 8); drive(1, 8);
      drive(0, 40);
      check("double_once", n_double, 1);
      check("double_no_short", n_short, 0);
      check("double_cnt", int'(press_cnt), 2);

      // click then long
      do_reset("r5");
      drive(1, 8); drive(0, 8); drive(1, 60);
      check("cl_short", n_short, 1);
      check("cl_long", n_long, 1);
      check("cl_held", int'(held), 1);
      drive(0, 20);

      // reset mid-PRESS1 and mid-GAP
      do_reset("r6");
      drive(1, 5);
      do_reset("mid_press1");
      db = 1'b0;
      drive(0, 4); drive(1, 6); drive(0, 6);
      do_reset("mid_gap");
      drive(0, 60);
      check("mid_no_late", n_short + n_long + n_double, 0);

      // counter wrap
      do_reset("r7");
      for (int i = 0; i < 256; i++) begin
         drive(1, 2);
         drive(0, 2);
      end
      drive(0, 40);
      check("wrap_cnt", int'(press_cnt), 0);

      // random gestures, including reset with db high
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            db = 1'($urandom_range(0, 1));
            do_reset("rnd");
         end
         drive(1'($urandom_range(0, 1)), $urandom_range(1, 70));
      end
      drive(0, 80);

      check("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
